// File: rtl/bp_be_fe_if_ctl.sv
// bp_be_fe_if_ctl: BE-side endpoint of the FE<->BE interface.
// - Buffers incoming fe_queue packets (fetch / exception) in a circular FIFO for BE issue.
// - Holds one outgoing fe_cmd packet (redirect, attaboy, fence, fill) in a register for the FE.
// - Runs a flush window from acceptance of any non-attaboy command until the FE consumes it;
//   inside the window buffered and arriving fe_queue packets are stale and are discarded.
// - Optional macro BP_BE_FE_IF_PERF_EN adds drop_cnt_o (saturating) and attaboy_cnt_o (wrapping).
// Packet layouts (vaddr_width_p = V):
//   fe_queue : [V+4] msg type (1 = exception), [V+3:V] exception code, [V-1:0] pc
//   fe_cmd   : [V+2:V] opcode, [V-1:0] vaddr
module bp_be_fe_if_ctl
  #(parameter int vaddr_width_p = 39
   ,parameter int queue_els_p   = 4
   ,localparam int fe_queue_width_lp = vaddr_width_p + 5
   ,localparam int fe_cmd_width_lp   = vaddr_width_p + 3
   )
  (input  logic                         clk_i
  ,input  logic                         reset_i
  ,input  logic [fe_queue_width_lp-1:0] fe_queue_i
  ,input  logic                         fe_queue_v_i
  ,output logic                         fe_queue_ready_o
  ,output logic [fe_queue_width_lp-1:0] issue_pkt_o
  ,output logic                         issue_v_o
  ,input  logic                         issue_yumi_i
  ,input  logic [fe_cmd_width_lp-1:0]   cmd_i
  ,input  logic                         cmd_v_i
  ,output logic                         cmd_ready_o
  ,output logic [fe_cmd_width_lp-1:0]   fe_cmd_o
  ,output logic                         fe_cmd_v_o
  ,input  logic                         fe_cmd_yumi_i
`ifdef BP_BE_FE_IF_PERF_EN
  ,output logic [31:0]                  drop_cnt_o
  ,output logic [31:0]                  attaboy_cnt_o
`endif
  ,output logic                         flushing_o
  );

  localparam int AW = $clog2(queue_els_p);
  localparam int PW = AW + 1;
  localparam logic [2:0] e_op_attaboy = 3'd4;

  typedef enum logic {e_run = 1'b0, e_flush = 1'b1} state_e;

  state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [fe_queue_width_lp-1:0] mem_q [queue_els_p];
  logic exc_block_q, exc_block_d;
  logic [fe_cmd_width_lp-1:0] fe_cmd_q, fe_cmd_d;
  logic fe_cmd_v_q, fe_cmd_v_d;

  logic full, empty, enq, deq;
  logic cmd_accept, nonatta_accept, fe_cmd_taken, leave_flush;

  // Wrap bit differs with equal index => full; identical pointers => empty.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign cmd_ready_o    = ~fe_cmd_v_q | fe_cmd_yumi_i;
  assign cmd_accept     = cmd_v_i & cmd_ready_o;
  assign nonatta_accept = cmd_accept & (cmd_i[fe_cmd_width_lp-1 -: 3] != e_op_attaboy);
  assign fe_cmd_taken   = fe_cmd_yumi_i & fe_cmd_v_q;
  // A back-to-back non-attaboy in the same cycle keeps the window open.
  assign leave_flush    = fe_cmd_taken & (fe_cmd_q[fe_cmd_width_lp-1 -: 3] != e_op_attaboy)
                          & ~nonatta_accept;

  // Arrivals are only buffered while running; a clear on the same edge overrides the write.
  assign enq = fe_queue_v_i & fe_queue_ready_o & (state_q == e_run);
  assign deq = issue_yumi_i & issue_v_o;

  assign issue_pkt_o = mem_q[rd_ptr_q[AW-1:0]];
  assign fe_cmd_o    = fe_cmd_q;
  assign fe_cmd_v_o  = fe_cmd_v_q;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_run;
    else         state_q <= state_d;
  end

  // Next state: enter the window on any non-attaboy command, leave when the FE takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_run:   if (nonatta_accept) state_d = e_flush;
      e_flush: if (leave_flush)    state_d = e_run;
      default: state_d = e_run;
    endcase
  end

  // FSM-driven outputs; ready has no path from issue_yumi_i, only from registered pointers.
  always_comb begin
    flushing_o       = (state_q == e_flush);
    issue_v_o        = ~empty & (state_q == e_run) & ~exc_block_q;
    fe_queue_ready_o = ~reset_i & ((state_q == e_flush) | ~full);
  end

  // Next-state for pointers, exception block and command register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    exc_block_d = exc_block_q;
    fe_cmd_d    = fe_cmd_q;
    fe_cmd_v_d  = fe_cmd_v_q;

    if (nonatta_accept) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if ((state_q == e_flush) && leave_flush)
      exc_block_d = 1'b0;
    else if (deq && issue_pkt_o[fe_queue_width_lp-1])
      exc_block_d = 1'b1;

    if (cmd_accept) begin
      fe_cmd_d   = cmd_i;
      fe_cmd_v_d = 1'b1;
    end else if (fe_cmd_taken) begin
      fe_cmd_v_d = 1'b0;
    end
  end

  // Control and command registers; reset discards everything in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      exc_block_q <= 1'b0;
      fe_cmd_q    <= '0;
      fe_cmd_v_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      exc_block_q <= exc_block_d;
      fe_cmd_q    <= fe_cmd_d;
      fe_cmd_v_q  <= fe_cmd_v_d;
    end
  end

  // Packet storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= fe_queue_i;
  end

`ifdef BP_BE_FE_IF_PERF_EN
  logic [31:0] drop_cnt_q, drop_cnt_d, attaboy_cnt_q, attaboy_cnt_d;
  logic [PW-1:0] occ;
  logic [31:0] drop_inc;
  logic drop_arrive;

  assign occ         = wr_ptr_q - rd_ptr_q;
  assign drop_arrive = fe_queue_v_i & fe_queue_ready_o & ((state_q == e_flush) | nonatta_accept);

  // Drops = entries wiped by a clear (minus one consumed that cycle) plus discarded arrivals.
  always_comb begin
    drop_inc = 32'(drop_arrive);
    if (nonatta_accept) drop_inc = drop_inc + 32'(occ) - 32'(deq);
    if (drop_inc > (32'hFFFF_FFFF - drop_cnt_q)) drop_cnt_d = 32'hFFFF_FFFF;
    else                                         drop_cnt_d = drop_cnt_q + drop_inc;
    attaboy_cnt_d = attaboy_cnt_q;
    if (fe_cmd_taken && (fe_cmd_q[fe_cmd_width_lp-1 -: 3] == e_op_attaboy))
      attaboy_cnt_d = attaboy_cnt_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q    <= '0;
      attaboy_cnt_q <= '0;
    end else begin
      drop_cnt_q    <= drop_cnt_d;
      attaboy_cnt_q <= attaboy_cnt_d;
    end
  end

  assign drop_cnt_o    = drop_cnt_q;
  assign attaboy_cnt_o = attaboy_cnt_q;
`endif

endmodule

// File: tb/tb_bp_be_fe_if_ctl.sv
// Directed bench for bp_be_fe_if_ctl (default 39-bit vaddr, 4-entry queue).
// Counter checks are compiled in when BP_BE_FE_IF_PERF_EN is defined.
module tb_bp_be_fe_if_ctl;
  localparam int V  = 39;
  localparam int QW = V + 5;
  localparam int CW = V + 3;

  localparam logic [2:0] OP_REDIRECT  = 3'd0;
  localparam logic [2:0] OP_ITLB_FILL = 3'd1;
  localparam logic [2:0] OP_ATTABOY   = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic [QW-1:0] fq;
  logic          fq_v;
  logic          fq_ready;
  logic [QW-1:0] issue_pkt;
  logic          issue_v;
  logic          issue_yumi;
  logic [CW-1:0] cmd;
  logic          cmd_v;
  logic          cmd_ready;
  logic [CW-1:0] fe_cmd;
  logic          fe_cmd_v;
  logic          fe_cmd_yumi;
  logic          flushing;
`ifdef BP_BE_FE_IF_PERF_EN
  logic [31:0]   drop_cnt;
  logic [31:0]   attaboy_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bp_be_fe_if_ctl dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .fe_queue_i       (fq),
    .fe_queue_v_i     (fq_v),
    .fe_queue_ready_o (fq_ready),
    .issue_pkt_o      (issue_pkt),
    .issue_v_o        (issue_v),
    .issue_yumi_i     (issue_yumi),
    .cmd_i            (cmd),
    .cmd_v_i          (cmd_v),
    .cmd_ready_o      (cmd_ready),
    .fe_cmd_o         (fe_cmd),
    .fe_cmd_v_o       (fe_cmd_v),
    .fe_cmd_yumi_i    (fe_cmd_yumi),
`ifdef BP_BE_FE_IF_PERF_EN
    .drop_cnt_o       (drop_cnt),
    .attaboy_cnt_o    (attaboy_cnt),
`endif
    .flushing_o       (flushing)
  );

  function automatic logic [QW-1:0] fetch_pkt(input logic [V-1:0] pc);
    return {1'b0, 4'h0, pc};
  endfunction

  function automatic logic [QW-1:0] exc_pkt(input logic [V-1:0] pc);
    return {1'b1, 4'h1, pc};
  endfunction

  function automatic logic [CW-1:0] mk_cmd(input logic [2:0] op, input logic [V-1:0] va);
    return {op, va};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fq = '0; fq_v = 1'b0; issue_yumi = 1'b0;
    cmd = '0; cmd_v = 1'b0; fe_cmd_yumi = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fq_ready", fq_ready, 0);
    chk("rst_issue_v", issue_v, 0);
    chk("rst_fe_cmd_v", fe_cmd_v, 0);
    chk("rst_fe_cmd", fe_cmd, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_flushing", flushing, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_fq_ready", fq_ready, 1);
    tick();

    // Three fetch packets, in-order issue, no bypass
    fq_v = 1'b1; fq = fetch_pkt(39'h0080000000);
    #1 chk("no_bypass", issue_v, 0);
    tick();
    fq = fetch_pkt(39'h0080000004);
    #1 chk("t1_issue_v", issue_v, 1);
    chk("t1_first_pc", issue_pkt[V-1:0], 39'h0080000000);
    tick();
    fq = fetch_pkt(39'h0080000008);
    tick();
    fq_v = 1'b0;
    issue_yumi = 1'b1;
    #1 chk("t1_pc0", issue_pkt[V-1:0], 39'h0080000000);
    tick();
    chk("t1_pc1", issue_pkt[V-1:0], 39'h0080000004);
    tick();
    chk("t1_pc2", issue_pkt[V-1:0], 39'h0080000008);
    tick();
    issue_yumi = 1'b0;
    #1 chk("t1_drained", issue_v, 0);

    // Fill the queue, ready drops when full, one yumi reopens it
    for (int i = 0; i < 4; i++) begin
      fq_v = 1'b1; fq = fetch_pkt(39'h0080000010 + 39'(4 * i));
      #1 chk("fill_ready", fq_ready, 1);
      tick();
    end
    fq_v = 1'b0;
    #1 chk("full_ready", fq_ready, 0);
    chk("full_head_pc", issue_pkt[V-1:0], 39'h0080000010);
    issue_yumi = 1'b1;
    #1 chk("full_no_comb_ready", fq_ready, 0);
    tick();
    issue_yumi = 1'b0;
    #1 chk("reopen_ready", fq_ready, 1);
    chk("reopen_head_pc", issue_pkt[V-1:0], 39'h0080000014);

    // Redirect with 3 buffered; 2 packets arrive in the window; FE takes it after 5 cycles
    cmd_v = 1'b1; cmd = mk_cmd(OP_REDIRECT, 39'h0080001000);
    #1 chk("redir_cmd_ready", cmd_ready, 1);
    tick();
    cmd_v = 1'b0;
    #1 chk("redir_flushing", flushing, 1);
    chk("redir_issue_v", issue_v, 0);
    chk("redir_fe_cmd_v", fe_cmd_v, 1);
    chk("redir_vaddr", fe_cmd[V-1:0], 39'h0080001000);
    chk("redir_opcode", fe_cmd[CW-1 -: 3], OP_REDIRECT);
    chk("redir_fq_ready", fq_ready, 1);
    for (int i = 0; i < 5; i++) begin
      fq_v = (i < 2);
      fq = fetch_pkt(39'h0080000030 + 39'(4 * i));
      fe_cmd_yumi = (i == 4);
      issue_yumi = (i == 1);
      #1 chk("window_issue_v", issue_v, 0);
      tick();
    end
    fq_v = 1'b0; fe_cmd_yumi = 1'b0; issue_yumi = 1'b0;
    #1 chk("post_redir_flushing", flushing, 0);
    chk("post_redir_fe_cmd_v", fe_cmd_v, 0);
    chk("post_redir_empty", issue_v, 0);
`ifdef BP_BE_FE_IF_PERF_EN
    chk("drop_cnt_5", drop_cnt, 5);
`endif

    // Exception packet blocks issue until the fill command is taken by the FE
    fq_v = 1'b1; fq = exc_pkt(39'h0080002000);
    tick();
    fq = fetch_pkt(39'h0080002004);
    tick();
    fq_v = 1'b0;
    #1 chk("exc_issue_v", issue_v, 1);
    chk("exc_msg_type", issue_pkt[QW-1], 1);
    issue_yumi = 1'b1;
    tick();
    issue_yumi = 1'b0;
    #1 chk("exc_block", issue_v, 0);
    tick(); tick();
    chk("exc_block_hold", issue_v, 0);
    cmd_v = 1'b1; cmd = mk_cmd(OP_ITLB_FILL, 39'h0080002000);
    tick();
    cmd_v = 1'b0; fe_cmd_yumi = 1'b1;
    #1 chk("fill_flushing", flushing, 1);
    tick();
    fe_cmd_yumi = 1'b0;
    #1 chk("fill_done", flushing, 0);
    chk("fill_cleared", issue_v, 0);
    fq_v = 1'b1; fq = fetch_pkt(39'h0080003000);
    tick();
    fq_v = 1'b0;
    #1 chk("unblocked_issue_v", issue_v, 1);
    chk("unblocked_pc", issue_pkt[V-1:0], 39'h0080003000);
    issue_yumi = 1'b1;
    tick();
    issue_yumi = 1'b0;
`ifdef BP_BE_FE_IF_PERF_EN
    chk("drop_cnt_6", drop_cnt, 6);
`endif

    // Attaboy behind a busy command register
    cmd_v = 1'b1; cmd = mk_cmd(OP_REDIRECT, 39'h0080004000);
    tick();
    cmd = mk_cmd(OP_ATTABOY, 39'h0);
    #1 chk("atta_busy_ready", cmd_ready, 0);
    chk("atta_busy_v", fe_cmd_v, 1);
    tick();
    chk("atta_held_ready", cmd_ready, 0);
    chk("atta_stable_vaddr", fe_cmd[V-1:0], 39'h0080004000);
    fe_cmd_yumi = 1'b1;
    #1 chk("atta_yumi_ready", cmd_ready, 1);
    tick();
    cmd_v = 1'b0; fe_cmd_yumi = 1'b0;
    #1 chk("atta_loaded_v", fe_cmd_v, 1);
    chk("atta_loaded_op", fe_cmd[CW-1 -: 3], OP_ATTABOY);
    chk("atta_run", flushing, 0);
    fe_cmd_yumi = 1'b1;
    tick();
    fe_cmd_yumi = 1'b0;
    #1 chk("atta_consumed", fe_cmd_v, 0);
`ifdef BP_BE_FE_IF_PERF_EN
    chk("attaboy_cnt_1", attaboy_cnt, 1);
`endif

    // Asynchronous reset in the middle of a flush window
    fq_v = 1'b1; fq = fetch_pkt(39'h0080005000);
    tick();
    fq = fetch_pkt(39'h0080005004);
    tick();
    fq_v = 1'b0;
    #1 chk("pre_flush_issue_v", issue_v, 1);
    cmd_v = 1'b1; cmd = mk_cmd(OP_REDIRECT, 39'h0080006000);
    tick();
    cmd_v = 1'b0;
    #1 chk("mid_flush", flushing, 1);
`ifdef BP_BE_FE_IF_PERF_EN
    chk("drop_cnt_8", drop_cnt, 8);
`endif
    #1 rst = 1'b1;
    #1;
    chk("arst_flushing", flushing, 0);
    chk("arst_fe_cmd_v", fe_cmd_v, 0);
    chk("arst_fe_cmd", fe_cmd, 0);
    chk("arst_issue_v", issue_v, 0);
    chk("arst_fq_ready", fq_ready, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
`ifdef BP_BE_FE_IF_PERF_EN
    chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_attaboy_cnt", attaboy_cnt, 0);
`endif
    tick(); tick();
    rst = 1'b0;
    #1 chk("post_arst_fq_ready", fq_ready, 1);
    chk("post_arst_issue_v", issue_v, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
